vx_raster_stamp_queue: RTL and testbench

VX_RASTER_STAMP_QUEUE -- requirements
Module: VX_raster_stamp_queue

---
 rtl/vx_raster_stamp_queue.sv | 123 ++++++++++++
 tb/tb_vx_raster_stamp_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_raster_stamp_queue.sv
// Stamp FIFO between rasterizer stages; head entry and all status outputs come from registers.
// Optional feature: define RASTER_STAMP_DROP_EMPTY_EN to discard empty (mask == 0) non-last stamps.
module vx_raster_stamp_queue #(
    parameter int DIM_BITS  = 16,
    parameter int DATA_BITS = 32,
    parameter int PID_BITS  = 16,
    parameter int DEPTH     = 8,
    localparam int SW = 2*(DIM_BITS-1) + 4 + 12*DATA_BITS + PID_BITS,
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [SW-1:0] in_stamp,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [SW-1:0] out_stamp,
    output logic          out_last,
    input  logic          out_ready,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          done,
    output logic [31:0]   drop_count
);

    localparam int AW       = $clog2(DEPTH);
    localparam int MASK_LSB = 12*DATA_BITS + PID_BITS;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic [31:0]   drop_count_q, drop_count_d;
    logic [SW:0]   mem_q [DEPTH];
    logic [SW:0]   head;
    logic          push;
    logic          pop;
    logic          drop;
    logic          store;

    assign head = mem_q[rd_ptr_q];

    // Handshake decode; flush cancels any push or pop presented with it.
    always_comb begin
        push = in_valid & in_ready_q & ~flush;
        pop  = out_valid_q & out_ready & ~flush;
`ifdef RASTER_STAMP_DROP_EMPTY_EN
        drop = push & (in_stamp[MASK_LSB +: 4] == 4'b0000) & ~in_last;
`else
        drop = 1'b0;
`endif
        store = push & ~drop;
    end

    // Next-state for pointers, occupancy, status and drop counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        done_d       = 1'b0;
        drop_count_d = drop_count_q + 32'(drop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(store) - CW'(pop);
            done_d  = pop & head[SW];
        end
        in_ready_d  = (count_d < CW'(DEPTH));
        out_valid_d = (count_d != CW'(0));
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            drop_count_q <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Entry storage is not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (store && reset) begin
            mem_q[wr_ptr_q] <= {in_last, in_stamp};
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_stamp  = head[SW-1:0];
    assign out_last   = head[SW];
    assign count      = count_q;
    assign done       = done_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vx_raster_stamp_queue.sv
// Self-checking bench for vx_raster_stamp_queue: vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_vx_raster_stamp_queue;

    localparam int DIM_BITS  = 16;
    localparam int DATA_BITS = 32;
    localparam int PID_BITS  = 16;
    localparam int DEPTH     = 8;
    localparam int SW = 2*(DIM_BITS-1) + 4 + 12*DATA_BITS + PID_BITS;
    localparam int CW = $clog2(DEPTH+1);
    localparam int XW = SW + 1;
`ifdef RASTER_STAMP_DROP_EMPTY_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [SW-1:0] in_stamp;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [SW-1:0] out_stamp;
    logic          out_last;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;
    logic          done;
    logic [31:0]   drop_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [SW:0] mq[$];
    logic        m_done;
    logic [31:0] m_drop;

    always #5 clk = ~clk;

    vx_raster_stamp_queue #(
        .DIM_BITS(DIM_BITS), .DATA_BITS(DATA_BITS), .PID_BITS(PID_BITS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_stamp(in_stamp), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_stamp(out_stamp), .out_last(out_last), .out_ready(out_ready),
        .flush(flush), .count(count), .done(done), .drop_count(drop_count)
    );

    typedef struct {
        logic                v;
        logic [PID_BITS-1:0] pid;
        logic                last;
        logic                ordy;
        logic                fl;
        int                  e_cnt;
        logic                e_ov;
        logic [PID_BITS-1:0] e_pid;
        logic                e_done;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input logic [PID_BITS-1:0] pid, input logic [3:0] mask);
        logic [12*DATA_BITS-1:0] bc;
        logic [DIM_BITS-2:0]     px;
        logic [DIM_BITS-2:0]     py;
        for (int i = 0; i < 12; i++) bc[i*DATA_BITS +: DATA_BITS] = $urandom;
        px = (DIM_BITS-1)'($urandom);
        py = (DIM_BITS-1)'($urandom);
        return {px, py, mask, bc, pid};
    endfunction

    task automatic drive(input logic v, input logic [PID_BITS-1:0] pid, input logic [3:0] mask,
                         input logic last, input logic ordy, input logic fl);
        in_valid  = v;
        in_stamp  = mk(pid, mask);
        in_last   = last;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pid(input string name, input int pid);
        chk(name, XW'(out_stamp[PID_BITS-1:0]), XW'(pid));
    endtask

    // Reference: plain FIFO of {last, stamp}, evaluated on the current inputs before the edge.
    task automatic model_step();
        bit can_push;
        bit can_pop;
        bit popped_last;
        can_push    = mq.size() < DEPTH;
        can_pop     = mq.size() != 0;
        popped_last = 1'b0;
        if (flush) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            if (can_pop && out_ready) begin
                popped_last = mq[0][SW];
                void'(mq.pop_front());
            end
            if (can_push && in_valid) begin
                if (DROP_EN && in_stamp[12*DATA_BITS+PID_BITS +: 4] == 4'h0 && !in_last)
                    m_drop++;
                else
                    mq.push_back({in_last, in_stamp});
            end
            m_done = popped_last;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PID_BITS-1:0] exp_pids[$];
        logic [3:0]          rmask;
        int                  sel;

        tbl[0] = '{1'b1, 16'd5,  1'b0, 1'b0, 1'b0, 1, 1'b1, 16'd5,  1'b0};
        tbl[1] = '{1'b1, 16'd6,  1'b1, 1'b0, 1'b0, 2, 1'b1, 16'd5,  1'b0};
        tbl[2] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1, 1'b1, 16'd6,  1'b0};
        tbl[3] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 16'd0,  1'b1};
        tbl[4] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 16'd0,  1'b0};
        tbl[5] = '{1'b1, 16'd9,  1'b1, 1'b1, 1'b0, 1, 1'b1, 16'd9,  1'b0};
        tbl[6] = '{1'b1, 16'd10, 1'b0, 1'b1, 1'b0, 1, 1'b1, 16'd10, 1'b1};
        tbl[7] = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1, 1'b1, 16'd10, 1'b0};
        tbl[8] = '{1'b1, 16'd11, 1'b0, 1'b1, 1'b1, 0, 1'b0, 16'd0,  1'b0};
        tbl[9] = '{1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 0, 1'b0, 16'd0,  1'b0};

        // Reset with traffic presented: everything must come up empty.
        reset = 1'b0;
        drive(1'b1, 16'd1, 4'hF, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_count", XW'(count), XW'(0));
        chk("rst_out_valid", XW'(out_valid), XW'(0));
        chk("rst_done", XW'(done), XW'(0));
        chk("rst_drop", XW'(drop_count), XW'(0));
        reset = 1'b1;
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_in_ready", XW'(in_ready), XW'(1));

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].pid, 4'hF, tbl[i].last, tbl[i].ordy, tbl[i].fl);
            tick();
            chk($sformatf("tbl%0d_count", i), XW'(count), XW'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_out_valid", i), XW'(out_valid), XW'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_in_ready", i), XW'(in_ready), XW'(tbl[i].e_cnt < DEPTH));
            chk($sformatf("tbl%0d_done", i), XW'(done), XW'(tbl[i].e_done));
            if (tbl[i].e_ov) chk_pid($sformatf("tbl%0d_pid", i), tbl[i].e_pid);
        end

        // Fill to DEPTH with consumer stalled, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, PID_BITS'(i), 4'hF, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("full_count", XW'(count), XW'(DEPTH));
        chk("full_in_ready", XW'(in_ready), XW'(0));
        drive(1'b1, 16'd99, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_push_ignored", XW'(count), XW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            drive(i == 0, 16'd99, 4'hF, 1'b0, 1'b1, 1'b0);
            chk_pid($sformatf("drain_pid%0d", i), i);
            tick();
        end
        chk("drain_count", XW'(count), XW'(0));
        chk("drain_out_valid", XW'(out_valid), XW'(0));

        // Single push into empty queue: visible next cycle, not the same cycle.
        drive(1'b1, 16'd5, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("lat_no_passthru", XW'(out_valid), XW'(0));
        tick();
        chk("lat_out_valid", XW'(out_valid), XW'(1));
        chk_pid("lat_pid", 5);
        chk("lat_count", XW'(count), XW'(1));
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b1, 1'b0);
        tick();

        // Steady push+pop at occupancy 3 across two pointer wraps.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, PID_BITS'(i), 4'hF, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, PID_BITS'(c + 3), 4'hF, 1'b0, 1'b1, 1'b0);
            chk_pid($sformatf("pp_head%0d", c), c);
            tick();
            chk($sformatf("pp_count%0d", c), XW'(count), XW'(3));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b1, 1'b0);
            chk_pid($sformatf("pp_tail%0d", i), 20 + i);
            tick();
        end

        // done pulses exactly one cycle after popping a last-flagged entry.
        drive(1'b1, 16'd9, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b1, 1'b0);
        tick();
        chk("done_t1", XW'(done), XW'(1));
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        chk("done_t2", XW'(done), XW'(0));

        // Flush at count 5 with push and pop requested; head carries last.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, PID_BITS'(20 + i), 4'hF, i == 0, 1'b0, 1'b0);
            tick();
        end
        chk("pre_flush_count", XW'(count), XW'(5));
        drive(1'b1, 16'd30, 4'hF, 1'b0, 1'b1, 1'b1);
        tick();
        chk("flush_count", XW'(count), XW'(0));
        chk("flush_out_valid", XW'(out_valid), XW'(0));
        chk("flush_done", XW'(done), XW'(0));
        chk("flush_in_ready", XW'(in_ready), XW'(1));
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b1, 1'b0);
        tick();
        chk("post_flush_count", XW'(count), XW'(0));

        // Empty-mask handling: masks 0, F, 0 (last).
        drive(1'b1, 16'd40, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'd41, 4'hF, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'd42, 4'h0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("drop_stored", XW'(count), XW'(DROP_EN ? 2 : 3));
        chk("drop_count", XW'(drop_count), XW'(DROP_EN ? 1 : 0));
        exp_pids.delete();
        if (!DROP_EN) exp_pids.push_back(16'd40);
        exp_pids.push_back(16'd41);
        exp_pids.push_back(16'd42);
        foreach (exp_pids[i]) begin
            drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b1, 1'b0);
            chk_pid($sformatf("drop_order%0d", i), exp_pids[i]);
            tick();
        end
        chk("drop_tail_done", XW'(done), XW'(1));
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b0, 1'b1);
        tick();
        chk("drop_kept_on_flush", XW'(drop_count), XW'(DROP_EN ? 1 : 0));

        // Reset mid-operation with handshakes active.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, PID_BITS'(50 + i), 4'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        reset = 1'b0;
        drive(1'b1, 16'd60, 4'hF, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 16'd0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("midrst_count", XW'(count), XW'(0));
        chk("midrst_out_valid", XW'(out_valid), XW'(0));
        chk("midrst_drop", XW'(drop_count), XW'(0));
        tick();

        // Randomized traffic against the reference FIFO.
        mq.delete();
        m_done = 1'b0;
        m_drop = 32'd0;
        for (int c = 0; c < 1500; c++) begin
            sel = $urandom_range(0, 3);
            rmask = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
            drive($urandom_range(0, 3) != 0, PID_BITS'($urandom), rmask,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
            model_step();
            tick();
            chk("rnd_count", XW'(count), XW'(mq.size()));
            chk("rnd_out_valid", XW'(out_valid), XW'(mq.size() != 0));
            chk("rnd_in_ready", XW'(in_ready), XW'(mq.size() < DEPTH));
            chk("rnd_done", XW'(done), XW'(m_done));
            chk("rnd_drop", XW'(drop_count), XW'(m_drop));
            if (mq.size() != 0) chk("rnd_head", {out_last, out_stamp}, mq[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
